int_detect: RTL and testbench
=============================

# int_detect

Interrupt-detection stage directly downstream of the ECFG CSR. It collects the interrupt sources into ESTAT.IS: software bits, hardware lines, the constant timer and the inter-processor interrupt. It masks them with ECFG.LIE and CRMD.IE and presents a registered interrupt request to the commit stage. It also owns the TCFG/TVAL countdown timer that raises the timer interrupt.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock; only clock.
- `rst`  in  1  synchronous, active-high reset (sampled on `clk` rising edge).
- `ECFG`  in  32  ECFG CSR value; bits [12:0] are the local interrupt enables (LIE), bit 10 always 0.
- `CRMD_IE`  in  1  global interrupt enable.
- `hwi`  in  8  external hardware interrupt lines, level, asynchronous to `clk`.
- `ipi`  in  1  inter-processor interrupt, level, synchronous to `clk`.
- `CSRWR_ESTAT_EN`  in  1  write strobe, ESTAT software-interrupt bits.
- `CSRWR_ESTAT_data`  in  2  new SWI[1:0].
- `CSRWR_TCFG_EN`  in  1  write strobe, TCFG.
- `CSRWR_TCFG_data`  in  32  [0] En, [1] Periodic, [31:2] InitVal.
- `CSRWR_TICLR_EN`  in  1  write strobe, TICLR.
- `CSRWR_TICLR_data`  in  1  bit 0 of TICLR; 1 clears TI.
- `int_ack`  in  1  commit stage has taken the interrupt this cycle.
- `ESTAT_IS`  out  13  pending-interrupt vector.
- `TCFG`  out  32  TCFG CSR.
- `TVAL`  out  32  current timer value.
- `int_req`  out  1  registered interrupt request to commit.

## Operation
- All state is updated on `clk` rising edge.
- Reset (`rst`=1): `ESTAT_IS`, `TCFG`, `TVAL`, `int_req`, synchronizer flops and the timer-run flag all go to 0.
- `ESTAT_IS` bit map:
  - [1:0] SWI: loaded from `CSRWR_ESTAT_data` when `CSRWR_ESTAT_EN`; otherwise held.
  - [9:2] HWI: follow the synchronized `hwi`, level, no latching.
  - [10]: constant 0.
  - [11] TI: sticky.
  - [12] IPI: `ipi` registered, level.
- TI rules:
  - Set by a timer expiry.
  - Cleared by `CSRWR_TICLR_EN` with `CSRWR_TICLR_data`=1.
  - Expiry and clear in the same cycle: set wins, TI=1.
- Timer, TCFG write:
  - `TCFG`<=data and `TVAL`<={data[31:2],2'b00}.
  - Run flag<=data[0].
- Timer, running (run flag=1, no TCFG write this cycle):
  - `TVAL`!=0: `TVAL`<=`TVAL`-1.
  - `TVAL`==0: TI<=1.
    - Periodic=1: `TVAL`<={InitVal,2'b00} and keep running.
    - Periodic=0: run flag<=0 and `TVAL` holds 0 (one-shot, no further expiries).
- Timer, TCFG write in the same cycle as an expiry: the write governs `TVAL` and the run flag; TI is still set.
- `TVAL` arithmetic is 32-bit unsigned and never wraps below 0.
- Request:
  - `int_req`<=`CRMD_IE` & |(`ESTAT_IS` & `ECFG[12:0]`), computed from current register values.
  - When `int_ack`=1, `int_req`<=0 for the next cycle regardless of sources. This is a one-cycle bubble while commit clears CRMD.IE.
  - Sources are level: `int_req` reasserts afterwards if a source is still pending and enabled.

## Timing
- SWI write at edge k: `ESTAT_IS[1:0]` valid after edge k; `int_req` after edge k+1.
- IPI: sampled at edge k, IS[12] after k, `int_req` after k+1.
- HWI with `INT_HWI_SYNC_EN` (two flops):
  - `hwi` stable before edge k: sync stage after k, IS[9:2] after k+1, `int_req` after k+2.
  - Deassertion has the same latency.
- TCFG write at edge k with En=1, InitVal=N (so `TVAL`=4N after k):
  - `TVAL`=0 after edge k+4N.
  - TI=1 after k+4N+1.
  - `int_req` after k+4N+2, if enabled.
- `int_ack` at edge k: `int_req`=0 after k. Earliest reassertion is after k+1.
- `rst` overrides every write and the timer in the same edge.

## Configuration
- `INT_HWI_SYNC_EN` defined: `hwi` passes through a two-flop synchronizer before IS[9:2]; latency as above.
- `INT_HWI_SYNC_EN` undefined: single register stage. `hwi` before edge k gives IS[9:2] after k and `int_req` after k+1. Use only when `hwi` is already synchronous to `clk`.

## Test plan
- Reset, then ECFG=0x1FFF, CRMD_IE=1, SWI write 2'b01 -> ESTAT_IS=0x0001 next cycle, int_req=1 one cycle later; with ECFG=0 int_req stays 0.
- hwi=8'h04, ECFG=0x0010, CRMD_IE=1 (macro defined) -> IS=0x0010 two edges after, int_req third edge; hwi back to 0 -> IS clears with the same latency.
- TCFG write 0x0000000D (En=1, Periodic=0, InitVal=3) -> TVAL counts 12..0, TI=1 one edge after TVAL=0, TVAL holds 0 and no further expiry; TICLR=1 clears TI.
- TCFG write 0x0000000B (En=1, Periodic=1, InitVal=2) -> TVAL 8..0 then reloads 8; TI set each period; TICLR on the same cycle as an expiry leaves TI=1.
- Pending IPI with ECFG[12]=1, CRMD_IE=1, int_ack pulsed -> int_req 0 for exactly one cycle, then 1 again.
- rst asserted mid-countdown (TVAL=5) together with a TCFG write -> all outputs 0 next cycle, timer stopped.

Source files
------------

// File: rtl/int_detect.sv
// Interrupt detection: builds ESTAT.IS, runs the TCFG/TVAL timer and registers the request to commit.
// Optional macro INT_HWI_SYNC_EN adds a two-flop synchronizer on hwi (default: single register stage).
module int_detect (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ECFG,
   input  logic        CRMD_IE,
   input  logic [7:0]  hwi,
   input  logic        ipi,
   input  logic        CSRWR_ESTAT_EN,
   input  logic [1:0]  CSRWR_ESTAT_data,
   input  logic        CSRWR_TCFG_EN,
   input  logic [31:0] CSRWR_TCFG_data,
   input  logic        CSRWR_TICLR_EN,
   input  logic        CSRWR_TICLR_data,
   input  logic        int_ack,
   output logic [12:0] ESTAT_IS,
   output logic [31:0] TCFG,
   output logic [31:0] TVAL,
   output logic        int_req
);

   logic [1:0]  swi_q;
   logic [7:0]  hwi_is_q;
   logic        ti_q;
   logic        ipi_q;
   logic        run_q;
   logic [31:0] tcfg_q;
   logic [31:0] tval_q;
   logic        int_req_q;

   logic [7:0]  hwi_stage;
   logic        expire;
   logic [31:0] tval_nxt;
   logic        run_nxt;
   logic        ti_nxt;
   logic [31:0] reload_val;
   logic [12:0] is_masked;

   logic unused_ecfg;
   assign unused_ecfg = &{1'b0, ECFG[31:13]};

`ifdef INT_HWI_SYNC_EN
   logic [7:0] hwi_p0;

   // first synchronizer flop; ESTAT_IS[9:2] is the second
   always_ff @(posedge clk) begin
      if (rst) begin
         hwi_p0 <= 8'd0;
      end else begin
         hwi_p0 <= hwi;
      end
   end

   assign hwi_stage = hwi_p0;
`else
   assign hwi_stage = hwi;
`endif

   assign reload_val = {tcfg_q[31:2], 2'b00};
   assign expire     = run_q && (tval_q == 32'd0);

   always_comb begin
      tval_nxt = tval_q;
      run_nxt  = run_q;
      ti_nxt   = ti_q;

      // a TCFG write owns TVAL and the run flag even when it lands on an expiry
      if (CSRWR_TCFG_EN) begin
         tval_nxt = {CSRWR_TCFG_data[31:2], 2'b00};
         run_nxt  = CSRWR_TCFG_data[0];
      end else if (run_q) begin
         if (tval_q != 32'd0) begin
            tval_nxt = tval_q - 32'd1;
         end else if (tcfg_q[1]) begin
            tval_nxt = reload_val;
         end else begin
            run_nxt = 1'b0;
         end
      end

      if (CSRWR_TICLR_EN && CSRWR_TICLR_data) begin
         ti_nxt = 1'b0;
      end
      if (expire) begin
         ti_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         swi_q    <= 2'd0;
         hwi_is_q <= 8'd0;
         ti_q     <= 1'b0;
         ipi_q    <= 1'b0;
         run_q    <= 1'b0;
         tcfg_q   <= 32'd0;
         tval_q   <= 32'd0;
      end else begin
         if (CSRWR_ESTAT_EN) begin
            swi_q <= CSRWR_ESTAT_data;
         end
         if (CSRWR_TCFG_EN) begin
            tcfg_q <= CSRWR_TCFG_data;
         end
         hwi_is_q <= hwi_stage;
         ipi_q    <= ipi;
         ti_q     <= ti_nxt;
         run_q    <= run_nxt;
         tval_q   <= tval_nxt;
      end
   end

   assign ESTAT_IS  = {ipi_q, ti_q, 1'b0, hwi_is_q, swi_q};
   assign is_masked = ESTAT_IS & ECFG[12:0];

   // int_ack forces a one-cycle bubble while commit drops CRMD.IE
   always_ff @(posedge clk) begin
      if (rst) begin
         int_req_q <= 1'b0;
      end else if (int_ack) begin
         int_req_q <= 1'b0;
      end else begin
         int_req_q <= CRMD_IE && (is_masked != 13'd0);
      end
   end

   assign TCFG    = tcfg_q;
   assign TVAL    = tval_q;
   assign int_req = int_req_q;

endmodule

// File: tb/tb_int_detect.sv
// Self-checking bench for int_detect: directed scenarios plus a randomized run against a behavioural model.
module tb_int_detect;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ECFG;
   logic        CRMD_IE;
   logic [7:0]  hwi;
   logic        ipi;
   logic        CSRWR_ESTAT_EN;
   logic [1:0]  CSRWR_ESTAT_data;
   logic        CSRWR_TCFG_EN;
   logic [31:0] CSRWR_TCFG_data;
   logic        CSRWR_TICLR_EN;
   logic        CSRWR_TICLR_data;
   logic        int_ack;
   logic [12:0] ESTAT_IS;
   logic [31:0] TCFG;
   logic [31:0] TVAL;
   logic        int_req;

   int n_cmp = 0;
   int n_err = 0;

`ifdef INT_HWI_SYNC_EN
   localparam int HWI_LAT = 2;
`else
   localparam int HWI_LAT = 1;
`endif

   always #5 clk = ~clk;

   int_detect dut (
      .clk(clk), .rst(rst), .ECFG(ECFG), .CRMD_IE(CRMD_IE), .hwi(hwi), .ipi(ipi),
      .CSRWR_ESTAT_EN(CSRWR_ESTAT_EN), .CSRWR_ESTAT_data(CSRWR_ESTAT_data),
      .CSRWR_TCFG_EN(CSRWR_TCFG_EN), .CSRWR_TCFG_data(CSRWR_TCFG_data),
      .CSRWR_TICLR_EN(CSRWR_TICLR_EN), .CSRWR_TICLR_data(CSRWR_TICLR_data),
      .int_ack(int_ack), .ESTAT_IS(ESTAT_IS), .TCFG(TCFG), .TVAL(TVAL), .int_req(int_req)
   );

   // behavioural reference state
   logic [1:0]  m_swi = '0;
   logic [7:0]  m_hwi = '0;
   logic [7:0]  m_hwi_seen = '0;
   logic        m_ti = 1'b0;
   logic        m_ipi = 1'b0;
   logic        m_run = 1'b0;
   logic [31:0] m_tcfg = '0;
   logic [31:0] m_tval = '0;
   logic        m_req = 1'b0;

   task automatic model_step();
      logic [12:0] pending;
      logic        hit_zero;
      logic [7:0]  hwi_vis;
      if (rst) begin
         m_swi = '0; m_hwi = '0; m_hwi_seen = '0; m_ti = 1'b0; m_ipi = 1'b0;
         m_run = 1'b0; m_tcfg = '0; m_tval = '0; m_req = 1'b0;
         return;
      end
      pending  = {m_ipi, m_ti, 1'b0, m_hwi, m_swi};
      hit_zero = m_run && (m_tval == 32'd0);
      hwi_vis  = (HWI_LAT == 1) ? hwi : m_hwi_seen;
      m_req    = !int_ack && CRMD_IE && ((pending & ECFG[12:0]) != 13'd0);
      m_hwi_seen = hwi;
      m_hwi      = hwi_vis;
      m_ipi      = ipi;
      if (CSRWR_ESTAT_EN) m_swi = CSRWR_ESTAT_data;
      if (hit_zero) m_ti = 1'b1;
      else if (CSRWR_TICLR_EN && CSRWR_TICLR_data) m_ti = 1'b0;
      if (CSRWR_TCFG_EN) begin
         m_tcfg = CSRWR_TCFG_data;
         m_tval = {CSRWR_TCFG_data[31:2], 2'b00};
         m_run  = CSRWR_TCFG_data[0];
      end else if (m_run) begin
         if (m_tval > 32'd0)  m_tval = m_tval - 32'd1;
         else if (m_tcfg[1])  m_tval = m_tcfg[31:2] * 32'd4;
         else                 m_run = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic quiet();
      CSRWR_ESTAT_EN = 1'b0; CSRWR_TCFG_EN = 1'b0; CSRWR_TICLR_EN = 1'b0;
      CSRWR_ESTAT_data = '0; CSRWR_TCFG_data = '0; CSRWR_TICLR_data = 1'b0;
      int_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ECFG = 32'h1FFF; CRMD_IE = 1'b1; hwi = 8'hFF; ipi = 1'b1;
      quiet();
      CSRWR_TCFG_EN = 1'b1; CSRWR_TCFG_data = 32'h0000_0011;
      CSRWR_ESTAT_EN = 1'b1; CSRWR_ESTAT_data = 2'b11;
      tick(); tick();
      n_cmp++; if (ESTAT_IS !== 13'd0) begin n_err++; $display("FAIL reset_is: got %h expected 0", ESTAT_IS); end
      n_cmp++; if (TCFG !== 32'd0) begin n_err++; $display("FAIL reset_tcfg: got %h expected 0", TCFG); end
      n_cmp++; if (TVAL !== 32'd0) begin n_err++; $display("FAIL reset_tval: got %h expected 0", TVAL); end
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", int_req); end
      rst = 1'b0; hwi = 8'h00; ipi = 1'b0; quiet();
      repeat (3) tick();
   endtask

   task automatic test_swi();
      ECFG = 32'h1FFF; CRMD_IE = 1'b1;
      CSRWR_ESTAT_EN = 1'b1; CSRWR_ESTAT_data = 2'b01;
      tick(); quiet();
      n_cmp++; if (ESTAT_IS !== 13'h0001) begin n_err++; $display("FAIL swi_is: got %h expected 0001", ESTAT_IS); end
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL swi_req_early: got %b expected 0", int_req); end
      tick();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL swi_req: got %b expected 1", int_req); end
      ECFG = 32'h0;
      tick(); tick();
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL swi_masked: got %b expected 0", int_req); end
      CSRWR_ESTAT_EN = 1'b1; CSRWR_ESTAT_data = 2'b00;
      tick(); quiet(); tick();
   endtask

   task automatic test_hwi();
      ECFG = 32'h0010; CRMD_IE = 1'b1;
      for (int phase = 0; phase < 2; phase++) begin
         hwi = (phase == 0) ? 8'h04 : 8'h00;
         for (int i = 1; i <= HWI_LAT + 1; i++) begin
            logic [12:0] exp_is;
            logic        exp_req;
            tick();
            exp_is  = ((i >= HWI_LAT) == (phase == 0)) ? 13'h0010 : 13'h0000;
            exp_req = ((i >= HWI_LAT + 1) == (phase == 0));
            n_cmp++; if (ESTAT_IS !== exp_is) begin n_err++; $display("FAIL hwi_is[%0d,%0d]: got %h expected %h", phase, i, ESTAT_IS, exp_is); end
            n_cmp++; if (int_req !== exp_req) begin n_err++; $display("FAIL hwi_req[%0d,%0d]: got %b expected %b", phase, i, int_req, exp_req); end
         end
      end
      tick();
   endtask

   task automatic test_timer_oneshot();
      ECFG = 32'h0800; CRMD_IE = 1'b1;
      CSRWR_TCFG_EN = 1'b1; CSRWR_TCFG_data = 32'h0000_000D;
      tick(); quiet();
      n_cmp++; if (TCFG !== 32'h0000_000D) begin n_err++; $display("FAIL os_tcfg: got %h expected 0000000d", TCFG); end
      n_cmp++; if (TVAL !== 32'd12) begin n_err++; $display("FAIL os_tval_init: got %0d expected 12", TVAL); end
      for (int v = 11; v >= 0; v--) begin
         tick();
         n_cmp++; if (TVAL !== 32'(v) || ESTAT_IS[11] !== 1'b0) begin n_err++; $display("FAIL os_count: got tval=%0d ti=%b expected tval=%0d ti=0", TVAL, ESTAT_IS[11], v); end
      end
      tick();
      n_cmp++; if (ESTAT_IS[11] !== 1'b1 || TVAL !== 32'd0) begin n_err++; $display("FAIL os_expire: got ti=%b tval=%0d expected ti=1 tval=0", ESTAT_IS[11], TVAL); end
      tick();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL os_req: got %b expected 1", int_req); end
      repeat (5) tick();
      n_cmp++; if (TVAL !== 32'd0) begin n_err++; $display("FAIL os_hold: got %0d expected 0", TVAL); end
      CSRWR_TICLR_EN = 1'b1; CSRWR_TICLR_data = 1'b1;
      tick(); quiet();
      n_cmp++; if (ESTAT_IS[11] !== 1'b0) begin n_err++; $display("FAIL os_ticlr: got ti=%b expected 0", ESTAT_IS[11]); end
      repeat (6) tick();
      n_cmp++; if (ESTAT_IS[11] !== 1'b0 || int_req !== 1'b0) begin n_err++; $display("FAIL os_no_reexpire: got ti=%b req=%b expected 0 0", ESTAT_IS[11], int_req); end
   endtask

   task automatic test_timer_periodic();
      ECFG = 32'h0; CRMD_IE = 1'b0;
      CSRWR_TCFG_EN = 1'b1; CSRWR_TCFG_data = 32'h0000_000B;
      tick(); quiet();
      n_cmp++; if (TVAL !== 32'd8) begin n_err++; $display("FAIL per_init: got %0d expected 8", TVAL); end
      for (int v = 7; v >= 0; v--) begin
         tick();
         n_cmp++; if (TVAL !== 32'(v)) begin n_err++; $display("FAIL per_count: got %0d expected %0d", TVAL, v); end
      end
      tick();
      n_cmp++; if (TVAL !== 32'd8 || ESTAT_IS[11] !== 1'b1) begin n_err++; $display("FAIL per_reload: got tval=%0d ti=%b expected 8 1", TVAL, ESTAT_IS[11]); end
      CSRWR_TICLR_EN = 1'b1; CSRWR_TICLR_data = 1'b1;
      tick(); quiet();
      n_cmp++; if (TVAL !== 32'd7 || ESTAT_IS[11] !== 1'b0) begin n_err++; $display("FAIL per_clear: got tval=%0d ti=%b expected 7 0", TVAL, ESTAT_IS[11]); end
      repeat (7) tick();
      n_cmp++; if (TVAL !== 32'd0) begin n_err++; $display("FAIL per_zero2: got %0d expected 0", TVAL); end
      CSRWR_TICLR_EN = 1'b1; CSRWR_TICLR_data = 1'b1;
      tick(); quiet();
      n_cmp++; if (ESTAT_IS[11] !== 1'b1 || TVAL !== 32'd8) begin n_err++; $display("FAIL per_set_wins: got ti=%b tval=%0d expected 1 8", ESTAT_IS[11], TVAL); end
      CSRWR_TCFG_EN = 1'b1; CSRWR_TCFG_data = 32'h0;
      CSRWR_TICLR_EN = 1'b1; CSRWR_TICLR_data = 1'b1;
      tick(); quiet(); tick();
      n_cmp++; if (ESTAT_IS[11] !== 1'b0 || TVAL !== 32'd0) begin n_err++; $display("FAIL per_stop: got ti=%b tval=%0d expected 0 0", ESTAT_IS[11], TVAL); end
   endtask

   task automatic test_ack();
      ECFG = 32'h1000; CRMD_IE = 1'b1; ipi = 1'b1;
      tick(); tick();
      n_cmp++; if (int_req !== 1'b1 || ESTAT_IS !== 13'h1000) begin n_err++; $display("FAIL ack_pending: got req=%b is=%h expected 1 1000", int_req, ESTAT_IS); end
      int_ack = 1'b1;
      tick(); int_ack = 1'b0;
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL ack_bubble: got %b expected 0", int_req); end
      tick();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL ack_reassert: got %b expected 1", int_req); end
      ipi = 1'b0;
      tick(); tick();
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL ack_drop: got %b expected 0", int_req); end
   endtask

   task automatic test_reset_mid();
      ECFG = 32'h1FFF; CRMD_IE = 1'b1;
      CSRWR_TCFG_EN = 1'b1; CSRWR_TCFG_data = 32'h0000_000D;
      tick(); quiet();
      repeat (7) tick();
      n_cmp++; if (TVAL !== 32'd5) begin n_err++; $display("FAIL rm_pre: got %0d expected 5", TVAL); end
      rst = 1'b1; ipi = 1'b1;
      CSRWR_TCFG_EN = 1'b1; CSRWR_TCFG_data = 32'h0000_001F;
      CSRWR_ESTAT_EN = 1'b1; CSRWR_ESTAT_data = 2'b11;
      tick();
      rst = 1'b0; ipi = 1'b0; quiet();
      n_cmp++; if (ESTAT_IS !== 13'd0 || TCFG !== 32'd0 || TVAL !== 32'd0 || int_req !== 1'b0) begin
         n_err++; $display("FAIL rm_cleared: got is=%h tcfg=%h tval=%h req=%b expected all 0", ESTAT_IS, TCFG, TVAL, int_req);
      end
      repeat (12) tick();
      n_cmp++; if (TVAL !== 32'd0 || ESTAT_IS[11] !== 1'b0) begin n_err++; $display("FAIL rm_stopped: got tval=%0d ti=%b expected 0 0", TVAL, ESTAT_IS[11]); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         ECFG = $urandom() & 32'hFFFF_FBFF;
         if ($urandom_range(0, 3) == 0) ECFG = 32'h0800;
         CRMD_IE = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 7) == 0) hwi = 8'($urandom());
         if ($urandom_range(0, 5) == 0) ipi = ~ipi;
         CSRWR_ESTAT_EN = ($urandom_range(0, 9) == 0);
         CSRWR_ESTAT_data = 2'($urandom());
         CSRWR_TCFG_EN = ($urandom_range(0, 39) == 0);
         CSRWR_TCFG_data = {28'($urandom_range(0, 6)), 2'($urandom()), 2'($urandom())};
         CSRWR_TICLR_EN = ($urandom_range(0, 7) == 0);
         CSRWR_TICLR_data = 1'($urandom());
         int_ack = ($urandom_range(0, 5) == 0);
         tick();
         n_cmp++;
         if (ESTAT_IS !== {m_ipi, m_ti, 1'b0, m_hwi, m_swi} || TCFG !== m_tcfg || TVAL !== m_tval || int_req !== m_req) begin
            n_err++;
            $display("FAIL rand[%0d]: got is=%h tcfg=%h tval=%h req=%b expected is=%h tcfg=%h tval=%h req=%b",
                     c, ESTAT_IS, TCFG, TVAL, int_req, {m_ipi, m_ti, 1'b0, m_hwi, m_swi}, m_tcfg, m_tval, m_req);
         end
      end
      rst = 1'b0; quiet();
   endtask

   initial begin
      rst = 1'b1; ECFG = '0; CRMD_IE = 1'b0; hwi = '0; ipi = 1'b0;
      quiet();
      test_reset();
      test_swi();
      test_hwi();
      test_timer_oneshot();
      test_timer_periodic();
      test_ack();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
